oserdes_lite: RTL

Single-clock parallel-to-serial transmitter, the transmit-side counterpart of our input deserializer simulation model. It accepts 2-4 bit parallel words from fabric through a valid/ready handshake and shifts them out one bit per enabled CLK0 cycle on OQ. It sits between fabric TX logic and the output pad. It sends a fixed training pattern whenever fabric has no word ready, and it flags underruns once traffic has started.

---
 rtl/oserdes_lite.sv | 65 ++++++
 1 files changed

// File: rtl/oserdes_lite.sv
// oserdes_lite: parallel-to-serial transmitter with training fill and sticky underrun flag
module oserdes_lite #(
  parameter int DATA_WIDTH = 4,
  parameter BIT_ORDER = "LSB_FIRST",
  parameter logic [3:0] TRAIN_PATTERN = 4'b0101
) (
  input  logic CLK0,
  input  logic RST,
  input  logic OCE,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic D4,
  input  logic VALID_IN,
  output logic READY,
  input  logic T,
  output logic OQ,
  output logic TQ,
  output logic UNDERRUN,
  input  logic CLR_UNDERRUN
);
  if (DATA_WIDTH < 2 || DATA_WIDTH > 4) begin : g_bad_width
    $fatal(1, "oserdes_lite: DATA_WIDTH must be 2, 3 or 4");
  end
  localparam logic [1:0] LAST = 2'(DATA_WIDTH - 1);
  localparam bit MSB = (BIT_ORDER == "MSB_FIRST");
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [DATA_WIDTH-1:0] sr, word;
  logic [3:0] d;
  logic accept;
  assign d = {D4, D3, D2, D1};
  assign READY = OCE && (cnt == LAST);
  assign accept = READY && VALID_IN;
  assign OQ = sr[0];
  // sr[0] is the head bit, so the word is arranged with its first-sent bit at index 0
  always_comb begin
    word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) word[i] = MSB ? d[DATA_WIDTH-1-i] : d[i];
  end
  // bit counter, shift register, tristate, state and underrun flag
  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      sr <= '0;
      TQ <= 1'b1;
      cnt <= LAST;
      state <= IDLE;
      UNDERRUN <= 1'b0;
    end else begin
      if (OCE) begin
        if (READY) begin
          cnt <= '0;
          sr <= accept ? word : TRAIN_PATTERN[DATA_WIDTH-1:0];
          TQ <= (accept || state == RUN) ? T : TQ;
          if (accept) state <= RUN;
        end else begin
          cnt <= cnt + 2'd1;
          sr <= sr >> 1;
        end
      end
      UNDERRUN <= (READY && !VALID_IN && state == RUN) || (UNDERRUN && !CLR_UNDERRUN);
    end
  end
endmodule
